// File: rtl/rv32im_bus_arbiter.sv
// ----------------------------------------------------------------------------
// rv32im_bus_arbiter
// Wishbone arbiter and multiplexer that lets NUM_MASTERS requesters share one
// bus. It offers a fixed-priority or round-robin policy and an optional
// watchdog that errors out a stalled strobe.
//
// Ports
//   clk_i, reset_ni      clock, asynchronous active-low reset
//   ctrl_req_i           per-master bus request
//   ctrl_grant_o         one-hot grant, all-zero while idle (registered)
//   owner_o              index of the granted master (registered)
//   busy_o               a master holds the bus (registered)
//   m_adr_i/m_dat_i/     packed master payloads; master k occupies slice k
//   m_sel_i/m_cyc_i/
//   m_stb_i/m_we_i
//   m_dat_o              slave read data broadcast to every master
//   m_ack_o/m_err_o      per-master ack / err, only ever to the owner
//   s_adr_o ... s_we_o   shared bus driven from the owner's slices
//   s_dat_i/s_ack_i/     slave responses
//   s_err_i
//   timeout_o            one-cycle pulse when the watchdog fires
// ----------------------------------------------------------------------------
module rv32im_bus_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned ROUND_ROBIN    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
  input  logic [NUM_MASTERS-1:0]             ctrl_req_i,
  output logic [NUM_MASTERS-1:0]             ctrl_grant_o,
  output logic [$clog2(NUM_MASTERS)-1:0]     owner_o,
  output logic                               busy_o,
  input  logic [NUM_MASTERS*(XLEN-2)-1:0]    m_adr_i,
  input  logic [NUM_MASTERS*XLEN-1:0]        m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]           m_sel_i,
  input  logic [NUM_MASTERS-1:0]             m_cyc_i,
  input  logic [NUM_MASTERS-1:0]             m_stb_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  output logic [XLEN-1:0]                    m_dat_o,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
  output logic [NUM_MASTERS-1:0]             m_err_o,
  output logic [XLEN-3:0]                    s_adr_o,
  output logic [XLEN-1:0]                    s_dat_o,
  output logic [3:0]                         s_sel_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  input  logic [XLEN-1:0]                    s_dat_i,
  input  logic                               s_ack_i,
  input  logic                               s_err_i,
  output logic                               timeout_o
);

  localparam int unsigned AW       = XLEN - 2;
  localparam int unsigned SW       = 4;
  localparam int unsigned OW       = $clog2(NUM_MASTERS);
  localparam int unsigned CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WD_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam bit          RR_EN    = (ROUND_ROBIN != 0);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          wd_cnt_q, wd_cnt_d;

  logic                   win_found;
  logic [OW-1:0]          win_idx;
  int unsigned            scan_base;
  int unsigned            scan_idx;

  logic                   wd_stall;
  logic                   wd_fire;

  // Winner selection: scan upward starting just after a base index. Fixed
  // priority uses base N-1 so the scan starts at master 0; round-robin starts
  // just after the last winner.
  always_comb begin : pick_winner
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    scan_base = RR_EN ? 32'(rr_ptr_q) : NUM_MASTERS - 1;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      scan_idx = (scan_base + i) % NUM_MASTERS;
      if (!win_found && ctrl_req_i[OW'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = OW'(scan_idx);
      end
    end
  end

  // State register together with the grant bookkeeping it qualifies.
  always_ff @(posedge clk_i or negedge reset_ni) begin : state_reg
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= OW'(NUM_MASTERS - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic. A release always passes through IDLE, so a waiting
  // request is only considered on the cycle after the drop.
  always_comb begin : fsm_next
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_GRANTED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          rr_ptr_d         = win_idx;
        end
      end
      ST_GRANTED: begin
        if (!ctrl_req_i[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output decode: one-hot grant selects the owner's slices, zero when idle.
  always_comb begin : bus_mux
    ctrl_grant_o = grant_q;
    owner_o      = owner_q;
    busy_o       = (state_q == ST_GRANTED);
    s_adr_o      = '0;
    s_dat_o      = '0;
    s_sel_o      = '0;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*XLEN +: XLEN];
        s_sel_o = m_sel_i[k*SW +: SW];
        s_cyc_o = m_cyc_i[k];
        s_stb_o = m_stb_i[k];
        s_we_o  = m_we_i[k];
      end
    end
  end

  // Response routing; a slave ack in the expiry cycle masks the watchdog
  // because the stall term already excludes ack.
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = s_ack_i ? grant_q : '0;
  assign m_err_o   = (s_err_i || wd_fire) ? grant_q : '0;
  assign timeout_o = wd_fire;

  // Watchdog: count unanswered strobe cycles; fire on the last allowed one.
  assign wd_stall = busy_o && s_stb_o && !s_ack_i && !s_err_i;
  assign wd_fire  = WD_EN && wd_stall && (wd_cnt_q == CW'(WD_LIMIT));

  always_comb begin : wd_next
    wd_cnt_d = wd_cnt_q + CW'(1);
    if (!WD_EN || !wd_stall || wd_fire) begin
      wd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin : wd_reg
    if (!reset_ni) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32im_bus_arbiter
// Directed bench for rv32im_bus_arbiter. Instance a: 3 masters, fixed
// priority, 16-cycle watchdog. Instance b: 4 masters, round-robin, no
// watchdog. Inputs change 1 ns after the rising edge, outputs are checked
// in the same window.
// ----------------------------------------------------------------------------
module tb_rv32im_bus_arbiter;

  logic clk = 1'b0;
  logic reset_ni;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Instance a signals (3 masters)
  logic [2:0]  req_a, cyc_a, stb_a, we_a;
  logic [89:0] adr_a;
  logic [95:0] dat_a;
  logic [11:0] sel_a;
  logic [31:0] sdi_a;
  logic        ack_a, err_a;
  logic [2:0]  grant_a, mack_a, merr_a;
  logic [1:0]  owner_a;
  logic        busy_a, scyc_a, sstb_a, swe_a, tmo_a;
  logic [31:0] mdat_a, sdat_a;
  logic [29:0] sadr_a;
  logic [3:0]  ssel_a;

  // Instance b signals (4 masters)
  logic [3:0]   req_b, cyc_b, stb_b, we_b;
  logic [119:0] adr_b;
  logic [127:0] dat_b;
  logic [15:0]  sel_b;
  logic [31:0]  sdi_b;
  logic         ack_b, err_b;
  logic [3:0]   grant_b, mack_b, merr_b;
  logic [1:0]   owner_b;
  logic         busy_b, scyc_b, sstb_b, swe_b, tmo_b;
  logic [31:0]  mdat_b, sdat_b;
  logic [29:0]  sadr_b;
  logic [3:0]   ssel_b;

  rv32im_bus_arbiter #(
    .XLEN(32), .NUM_MASTERS(3), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk_i(clk), .reset_ni(reset_ni),
    .ctrl_req_i(req_a), .ctrl_grant_o(grant_a), .owner_o(owner_a), .busy_o(busy_a),
    .m_adr_i(adr_a), .m_dat_i(dat_a), .m_sel_i(sel_a),
    .m_cyc_i(cyc_a), .m_stb_i(stb_a), .m_we_i(we_a),
    .m_dat_o(mdat_a), .m_ack_o(mack_a), .m_err_o(merr_a),
    .s_adr_o(sadr_a), .s_dat_o(sdat_a), .s_sel_o(ssel_a),
    .s_cyc_o(scyc_a), .s_stb_o(sstb_a), .s_we_o(swe_a),
    .s_dat_i(sdi_a), .s_ack_i(ack_a), .s_err_i(err_a),
    .timeout_o(tmo_a)
  );

  rv32im_bus_arbiter #(
    .XLEN(32), .NUM_MASTERS(4), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk_i(clk), .reset_ni(reset_ni),
    .ctrl_req_i(req_b), .ctrl_grant_o(grant_b), .owner_o(owner_b), .busy_o(busy_b),
    .m_adr_i(adr_b), .m_dat_i(dat_b), .m_sel_i(sel_b),
    .m_cyc_i(cyc_b), .m_stb_i(stb_b), .m_we_i(we_b),
    .m_dat_o(mdat_b), .m_ack_o(mack_b), .m_err_o(merr_b),
    .s_adr_o(sadr_b), .s_dat_o(sdat_b), .s_sel_o(ssel_b),
    .s_cyc_o(scyc_b), .s_stb_o(sstb_b), .s_we_o(swe_b),
    .s_dat_i(sdi_b), .s_ack_i(ack_b), .s_err_i(err_b),
    .timeout_o(tmo_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (grant_a !== 3'b000) begin errors++; $display("FAIL reset_grant_a got=%b exp=000", grant_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    checks++; if (owner_a !== 2'd0) begin errors++; $display("FAIL reset_owner_a got=%0d exp=0", owner_a); end
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL reset_timeout_a got=%b exp=0", tmo_a); end
    checks++; if (scyc_a !== 1'b0) begin errors++; $display("FAIL reset_scyc_a got=%b exp=0", scyc_a); end
    checks++; if (grant_b !== 4'b0000) begin errors++; $display("FAIL reset_grant_b got=%b exp=0000", grant_b); end
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic test_fixed_priority();
    req_a = 3'b110;
    tick();
    checks++; if (grant_a !== 3'b010) begin errors++; $display("FAIL fp_grant1 got=%b exp=010", grant_a); end
    checks++; if (owner_a !== 2'd1) begin errors++; $display("FAIL fp_owner1 got=%0d exp=1", owner_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL fp_busy1 got=%b exp=1", busy_a); end
    req_a = 3'b100;
    tick();
    checks++; if (grant_a !== 3'b000) begin errors++; $display("FAIL fp_handover_gap got=%b exp=000", grant_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL fp_handover_busy got=%b exp=0", busy_a); end
    tick();
    checks++; if (grant_a !== 3'b100) begin errors++; $display("FAIL fp_grant2 got=%b exp=100", grant_a); end
    checks++; if (owner_a !== 2'd2) begin errors++; $display("FAIL fp_owner2 got=%0d exp=2", owner_a); end
    req_a = 3'b000;
    tick();
    tick();
    // A request held for a single cycle still wins
    req_a = 3'b010;
    tick();
    req_a = 3'b000;
    checks++; if (grant_a !== 3'b010) begin errors++; $display("FAIL fp_pulse_grant got=%b exp=010", grant_a); end
    tick();
    checks++; if (grant_a !== 3'b000) begin errors++; $display("FAIL fp_pulse_release got=%b exp=000", grant_a); end
    tick();
  endtask

  task automatic test_no_preempt();
    req_a = 3'b100;
    tick();
    checks++; if (grant_a !== 3'b100) begin errors++; $display("FAIL np_grant got=%b exp=100", grant_a); end
    req_a = 3'b101;
    tick();
    checks++; if (grant_a !== 3'b100) begin errors++; $display("FAIL np_hold1 got=%b exp=100", grant_a); end
    tick();
    checks++; if (grant_a !== 3'b100) begin errors++; $display("FAIL np_hold2 got=%b exp=100", grant_a); end
    req_a = 3'b001;
    tick();
    checks++; if (grant_a !== 3'b000) begin errors++; $display("FAIL np_gap got=%b exp=000", grant_a); end
    tick();
    checks++; if (grant_a !== 3'b001) begin errors++; $display("FAIL np_next got=%b exp=001", grant_a); end
    req_a = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_mux_ack();
    adr_a = {30'h0000_0222, 30'h00C0_0001, 30'h0000_0111};
    dat_a = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    sel_a = {4'h3, 4'hF, 4'h1};
    we_a  = 3'b010;
    cyc_a = 3'b111;
    stb_a = 3'b111;
    #1;
    checks++; if (sadr_a !== 30'h0) begin errors++; $display("FAIL mux_idle_adr got=%h exp=0", sadr_a); end
    checks++; if (scyc_a !== 1'b0 || sstb_a !== 1'b0) begin errors++; $display("FAIL mux_idle_strobes got=%b%b exp=00", scyc_a, sstb_a); end
    checks++; if (ssel_a !== 4'h0) begin errors++; $display("FAIL mux_idle_sel got=%h exp=0", ssel_a); end
    req_a = 3'b010;
    tick();
    ack_a = 1'b1;
    sdi_a = 32'h1234_5678;
    #1;
    checks++; if (sadr_a !== 30'h00C0_0001) begin errors++; $display("FAIL mux_adr got=%h exp=00c00001", sadr_a); end
    checks++; if (swe_a !== 1'b1) begin errors++; $display("FAIL mux_we got=%b exp=1", swe_a); end
    checks++; if (ssel_a !== 4'hF) begin errors++; $display("FAIL mux_sel got=%h exp=f", ssel_a); end
    checks++; if (sdat_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mux_dat got=%h exp=deadbeef", sdat_a); end
    checks++; if (scyc_a !== 1'b1) begin errors++; $display("FAIL mux_cyc got=%b exp=1", scyc_a); end
    checks++; if (mack_a !== 3'b010) begin errors++; $display("FAIL mux_ack got=%b exp=010", mack_a); end
    checks++; if (merr_a !== 3'b000) begin errors++; $display("FAIL mux_err_quiet got=%b exp=000", merr_a); end
    checks++; if (mdat_a !== 32'h1234_5678) begin errors++; $display("FAIL mux_rdata got=%h exp=12345678", mdat_a); end
    ack_a = 1'b0;
    err_a = 1'b1;
    #1;
    checks++; if (merr_a !== 3'b010) begin errors++; $display("FAIL mux_err got=%b exp=010", merr_a); end
    checks++; if (mack_a !== 3'b000) begin errors++; $display("FAIL mux_ack_quiet got=%b exp=000", mack_a); end
    err_a = 1'b0;
    req_a = 3'b000;
    cyc_a = 3'b000;
    stb_a = 3'b000;
    we_a  = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    logic exp_t;
    cyc_a = 3'b001;
    stb_a = 3'b001;
    req_a = 3'b001;
    tick();
    // Stalled cycles 1..16; only the 16th raises the error
    for (int k = 1; k <= 16; k++) begin
      exp_t = (k == 16);
      checks++; if (tmo_a !== exp_t) begin errors++; $display("FAIL wd_timeout_c%0d got=%b exp=%b", k, tmo_a, exp_t); end
      checks++; if (merr_a !== {2'b00, exp_t}) begin errors++; $display("FAIL wd_err_c%0d got=%b exp=00%b", k, merr_a, exp_t); end
      if (k < 16) tick();
    end
    tick();
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL wd_pulse_len got=%b exp=0", tmo_a); end
    checks++; if (grant_a !== 3'b001) begin errors++; $display("FAIL wd_grant_kept got=%b exp=001", grant_a); end
    req_a = 3'b000;
    stb_a = 3'b000;
    cyc_a = 3'b000;
    tick();
    cyc_a = 3'b001;
    stb_a = 3'b001;
    req_a = 3'b001;
    tick();
    for (int k = 1; k <= 15; k++) begin
      checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL wd2_early_c%0d got=%b exp=0", k, tmo_a); end
      tick();
    end
    ack_a = 1'b1;
    #1;
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL wd2_ack_timeout got=%b exp=0", tmo_a); end
    checks++; if (merr_a !== 3'b000) begin errors++; $display("FAIL wd2_ack_err got=%b exp=000", merr_a); end
    checks++; if (mack_a !== 3'b001) begin errors++; $display("FAIL wd2_ack got=%b exp=001", mack_a); end
    tick();
    ack_a = 1'b0;
    #1;
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL wd2_after_ack got=%b exp=0", tmo_a); end
    req_a = 3'b000;
    stb_a = 3'b000;
    cyc_a = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [4];
    logic [3:0] prev;
    seq[0] = 4'b0010;
    seq[1] = 4'b0100;
    seq[2] = 4'b1000;
    seq[3] = 4'b0001;
    req_b = 4'hF;
    tick();
    checks++; if (grant_b !== 4'b0001) begin errors++; $display("FAIL rr_first got=%b exp=0001", grant_b); end
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      req_b = ~prev;
      tick();
      checks++; if (grant_b !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d got=%b exp=0000", i, grant_b); end
      req_b = 4'hF;
      tick();
      checks++; if (grant_b !== seq[i]) begin errors++; $display("FAIL rr_step%0d got=%b exp=%b", i, grant_b, seq[i]); end
      prev = seq[i];
    end
    checks++; if (owner_b !== 2'd0) begin errors++; $display("FAIL rr_owner_wrap got=%0d exp=0", owner_b); end
    req_b = 4'h0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    req_a = 3'b111;
    cyc_a = 3'b111;
    stb_a = 3'b111;
    req_b = 4'hF;
    cyc_b = 4'hF;
    stb_b = 4'hF;
    tick();
    checks++; if (grant_a !== 3'b001) begin errors++; $display("FAIL ar_pre_grant_a got=%b exp=001", grant_a); end
    checks++; if (scyc_a !== 1'b1) begin errors++; $display("FAIL ar_pre_cyc_a got=%b exp=1", scyc_a); end
    checks++; if (grant_b !== 4'b0010) begin errors++; $display("FAIL ar_pre_grant_b got=%b exp=0010", grant_b); end
    #3;
    reset_ni = 1'b0;
    #1;
    checks++; if (grant_a !== 3'b000) begin errors++; $display("FAIL ar_grant_a got=%b exp=000", grant_a); end
    checks++; if (scyc_a !== 1'b0 || sstb_a !== 1'b0) begin errors++; $display("FAIL ar_strobes_a got=%b%b exp=00", scyc_a, sstb_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL ar_busy_a got=%b exp=0", busy_a); end
    checks++; if (grant_b !== 4'b0000) begin errors++; $display("FAIL ar_grant_b got=%b exp=0000", grant_b); end
    checks++; if (scyc_b !== 1'b0 || sstb_b !== 1'b0) begin errors++; $display("FAIL ar_strobes_b got=%b%b exp=00", scyc_b, sstb_b); end
    #2;
    reset_ni = 1'b1;
    tick();
    checks++; if (grant_a !== 3'b001) begin errors++; $display("FAIL ar_post_grant_a got=%b exp=001", grant_a); end
    checks++; if (grant_b !== 4'b0001) begin errors++; $display("FAIL ar_post_grant_b got=%b exp=0001", grant_b); end
    checks++; if (owner_b !== 2'd0) begin errors++; $display("FAIL ar_post_owner_b got=%0d exp=0", owner_b); end
    req_a = 3'b000;
    cyc_a = 3'b000;
    stb_a = 3'b000;
    req_b = 4'h0;
    cyc_b = 4'h0;
    stb_b = 4'h0;
    tick();
  endtask

  initial begin
    reset_ni = 1'b0;
    req_a = '0; cyc_a = '0; stb_a = '0; we_a = '0;
    adr_a = '0; dat_a = '0; sel_a = '0;
    sdi_a = '0; ack_a = 1'b0; err_a = 1'b0;
    req_b = '0; cyc_b = '0; stb_b = '0; we_b = '0;
    adr_b = '0; dat_b = '0; sel_b = '0;
    sdi_b = '0; ack_b = 1'b0; err_b = 1'b0;

    test_reset();
    test_fixed_priority();
    test_no_preempt();
    test_mux_ack();
    test_watchdog();
    test_round_robin();
    test_async_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
